// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

    localparam int unsigned XZR_ADDR = 31;
    localparam int unsigned REG_AW   = 5;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int unsigned ptr_width(input int unsigned nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin picker: one-hot grant, search starts just after last_grant.
module rr_grant_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PW-1:0]   last_grant,
    input  logic            stall,
    output logic [NREQ-1:0] grant
);

    int unsigned idx;

    always_comb begin
        grant = '0;
        idx   = 0;
        if (!stall) begin
            for (int unsigned off = 1; off <= NREQ; off++) begin
                idx = (32'(last_grant) + off) % NREQ;
                if (grant == '0 && req_valid[idx]) begin
                    grant[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with a registered write stage.
// Optional per-requester wait counters are enabled by defining REGWR_ARB_WAITCNT_EN.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned N    = 64,
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = REG_AW,
    parameter int unsigned CW   = 8,
    localparam int unsigned PW  = ptr_width(NREQ)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*N-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
`ifdef REGWR_ARB_WAITCNT_EN
    output logic [NREQ*CW-1:0] wait_cnt,
`endif
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [N-1:0]      wr_data,
    output logic [PW-1:0]     last_grant
);

    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("NREQ must be in 2..4");
    end
    if (CW < 1) begin : g_bad_cw
        $error("CW must be at least 1");
    end

    logic [NREQ-1:0] grant;
    logic            wr_en_d, wr_en_q;
    logic [AW-1:0]   wr_addr_d, wr_addr_q;
    logic [N-1:0]    wr_data_d, wr_data_q;
    logic [PW-1:0]   last_grant_d, last_grant_q;

    // Reset blocks grants too, so nothing is accepted during the reset cycle.
    rr_grant_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .stall      (stall | reset),
        .grant      (grant)
    );

    always_comb begin
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                wr_addr_d    = req_addr[i*AW +: AW];
                wr_data_d    = req_data[i*N +: N];
                last_grant_d = PW'(i);
                // XZR writes are consumed but never reach the register file.
                wr_en_d      = (req_addr[i*AW +: AW] != AW'(XZR_ADDR));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            last_grant_q <= PW'(NREQ - 1);
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef REGWR_ARB_WAITCNT_EN
    logic [NREQ*CW-1:0] wait_cnt_d, wait_cnt_q;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !grant[i] && !(&wait_cnt_q[i*CW +: CW])) begin
                wait_cnt_d[i*CW +: CW] = wait_cnt_q[i*CW +: CW] + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt = wait_cnt_q;
`endif

    assign req_ready  = grant;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a two-requester instance and a four-requester instance.
module tb_regfile_write_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Two-requester instance.
    logic        reset, stall;
    logic [1:0]  req_valid, req_ready;
    logic [9:0]  req_addr;
    logic [127:0] req_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [0:0]  last_grant;
`ifdef REGWR_ARB_WAITCNT_EN
    logic [3:0]  wait_cnt;
`endif

    regfile_write_arbiter #(
        .N    (64),
        .NREQ (2),
        .AW   (5),
        .CW   (2)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .stall      (stall),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
`ifdef REGWR_ARB_WAITCNT_EN
        .wait_cnt   (wait_cnt),
`endif
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .last_grant (last_grant)
    );

    // Four-requester instance.
    logic        rst4, stall4;
    logic [3:0]  valid4, ready4;
    logic [19:0] addr4;
    logic [255:0] data4;
    logic        wr_en4;
    logic [4:0]  wr_addr4;
    logic [63:0] wr_data4;
    logic [1:0]  lg4;
`ifdef REGWR_ARB_WAITCNT_EN
    logic [31:0] wait_cnt4;
`endif

    regfile_write_arbiter #(
        .N    (64),
        .NREQ (4),
        .AW   (5),
        .CW   (8)
    ) dut4 (
        .clock      (clk),
        .reset      (rst4),
        .stall      (stall4),
        .req_valid  (valid4),
        .req_addr   (addr4),
        .req_data   (data4),
        .req_ready  (ready4),
`ifdef REGWR_ARB_WAITCNT_EN
        .wait_cnt   (wait_cnt4),
`endif
        .wr_en      (wr_en4),
        .wr_addr    (wr_addr4),
        .wr_data    (wr_data4),
        .last_grant (lg4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        rst4 = 1'b1; stall4 = 1'b0; valid4 = '0;
        addr4 = {5'd4, 5'd3, 5'd2, 5'd1};
        data4 = {64'hD4, 64'hC3, 64'hB2, 64'hA1};
        step();
        step();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_last_grant", 64'(last_grant), 64'd1);
        check("rst_ready", 64'(req_ready), 64'd0);

        // Continuous contention alternates 0, 1, 0.
        reset = 1'b0;
        req_valid = 2'b11;
        req_addr = {5'd7, 5'd3};
        req_data = {64'hBB, 64'hAA};
        #1;
        check("rr_ready0", 64'(req_ready), 64'b01);
        step();
        check("rr_wr_en1", 64'(wr_en), 64'd1);
        check("rr_addr1", 64'(wr_addr), 64'd3);
        check("rr_data1", wr_data, 64'hAA);
        check("rr_ready1", 64'(req_ready), 64'b10);
        step();
        check("rr_wr_en2", 64'(wr_en), 64'd1);
        check("rr_addr2", 64'(wr_addr), 64'd7);
        check("rr_data2", wr_data, 64'hBB);
        check("rr_lg2", 64'(last_grant), 64'd1);
        check("rr_ready2", 64'(req_ready), 64'b01);
        step();
        check("rr_addr3", 64'(wr_addr), 64'd3);
        check("rr_lg3", 64'(last_grant), 64'd0);

        // XZR: accepted but not written.
        req_valid = 2'b01;
        req_addr = {5'd7, 5'd31};
        req_data = {64'hBB, 64'h55};
        #1;
        check("xzr_ready", 64'(req_ready), 64'b01);
        step();
        check("xzr_wr_en", 64'(wr_en), 64'd0);
        check("xzr_lg", 64'(last_grant), 64'd0);

        // Stall blocks grants; pointer resumes afterwards.
        req_valid = 2'b10;
        stall = 1'b1;
        #1;
        check("stall_ready0", 64'(req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall_wr_en%0d", k), 64'(wr_en), 64'd0);
            check($sformatf("stall_ready%0d", k + 1), 64'(req_ready), 64'd0);
        end
        stall = 1'b0;
        #1;
        check("unstall_ready", 64'(req_ready), 64'b10);
        step();
        check("unstall_wr_en", 64'(wr_en), 64'd1);
        check("unstall_addr", 64'(wr_addr), 64'd7);
        check("unstall_lg", 64'(last_grant), 64'd1);

        // Reset right after a transfer cancels the pending write.
        req_valid = 2'b01;
        req_addr = {5'd7, 5'd3};
        req_data = {64'hBB, 64'hAA};
        #1;
        check("mid_ready", 64'(req_ready), 64'b01);
        step();
        check("mid_wr_en_pre", 64'(wr_en), 64'd1);
        check("mid_lg_pre", 64'(last_grant), 64'd0);
        reset = 1'b1;
        #1;
        check("mid_ready_rst", 64'(req_ready), 64'd0);
        step();
        check("mid_wr_en", 64'(wr_en), 64'd0);
        check("mid_lg", 64'(last_grant), 64'd1);
        check("mid_addr", 64'(wr_addr), 64'd0);
        req_valid = '0;

`ifdef REGWR_ARB_WAITCNT_EN
        // Saturating wait count for requester 1 under stall, CW=2.
        reset = 1'b0;
        stall = 1'b1;
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("wcnt%0d", k), 64'(wait_cnt[3:2]), (k < 3) ? 64'(k + 1) : 64'd3);
        end
        check("wcnt_req0", 64'(wait_cnt[1:0]), 64'd0);
        stall = 1'b0;
        req_valid = '0;
`endif

        // NREQ=4: requesters 0, 2, 3 valid -> 0, 2, 3, 0, 2.
        rst4 = 1'b0;
        valid4 = 4'b1101;
        #1;
        check("n4_ready0", 64'(ready4), 64'b0001);
        step();
        check("n4_addr0", 64'(wr_addr4), 64'd1);
        check("n4_lg0", 64'(lg4), 64'd0);
        check("n4_ready1", 64'(ready4), 64'b0100);
        step();
        check("n4_addr1", 64'(wr_addr4), 64'd3);
        check("n4_data1", wr_data4, 64'hC3);
        check("n4_ready2", 64'(ready4), 64'b1000);
        step();
        check("n4_lg2", 64'(lg4), 64'd3);
        check("n4_ready3", 64'(ready4), 64'b0001);
        step();
        check("n4_ready4", 64'(ready4), 64'b0100);
        check("n4_wr_en", 64'(wr_en4), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
